// File: rtl/gibbs_segment_scheduler.sv
// Gibbs-sweep sequencer: walks every variable, drives the segment selector,
// hands the chosen segment to the value sampler and writes the result back.
module gibbs_segment_scheduler #(
  parameter int unsigned NUM_VARS    = 4,
  parameter int unsigned VAR_IDX_W   = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEL_LATENCY = 2,
  parameter logic [7:0]  SEED_INIT   = 8'd1
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic                 in_stop,
  input  logic [7:0]           in_num_sweeps,
  output logic                 out_bound_req,
  output logic [VAR_IDX_W-1:0] out_bound_var_idx,
  input  logic                 in_bound_valid,
  input  logic [DATA_W-1:0]    in_c_less_than,
  input  logic [DATA_W-1:0]    in_c_more_than,
  input  logic [1:0]           in_flag,
  output logic                 out_sel_reset,
  output logic                 out_sel_enable,
  output logic [7:0]           out_sel_seed,
  output logic [DATA_W-1:0]    out_sel_c_less_than,
  output logic [DATA_W-1:0]    out_sel_c_more_than,
  output logic [1:0]           out_sel_flag,
  input  logic [1:0]           in_seg_type,
  input  logic [DATA_W-1:0]    in_seg_from,
  input  logic [DATA_W-1:0]    in_seg_to,
  input  logic [DATA_W-1:0]    in_seg_weight,
  output logic                 out_samp_valid,
  input  logic                 in_samp_ready,
  output logic [1:0]           out_samp_type,
  output logic [DATA_W-1:0]    out_samp_from,
  output logic [DATA_W-1:0]    out_samp_to,
  output logic [DATA_W-1:0]    out_samp_weight,
  input  logic                 in_samp_done,
  input  logic [DATA_W-1:0]    in_samp_value,
  output logic                 out_wr_en,
  output logic [VAR_IDX_W-1:0] out_wr_var_idx,
  output logic [DATA_W-1:0]    out_wr_value,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [7:0]           out_sweep_count
);

  localparam int unsigned CNT_W = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SEL_LATENCY - 1);
  localparam logic [VAR_IDX_W-1:0] IDX_LAST = VAR_IDX_W'(NUM_VARS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_BOUND, S_SEL_RST, S_SEL_RUN, S_HANDOFF,
    S_WAIT_SAMP, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [VAR_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [7:0]           sweep_q, sweep_d;
  logic [7:0]           run_sweeps_q, run_sweeps_d;
  logic [7:0]           target_q, target_d;
  logic                 stop_q, stop_d;
  logic [DATA_W-1:0]    lt_q, lt_d, mt_q, mt_d;
  logic [1:0]           flag_q, flag_d;
  logic [1:0]           seg_type_q, seg_type_d;
  logic [DATA_W-1:0]    seg_from_q, seg_from_d, seg_to_q, seg_to_d;
  logic [DATA_W-1:0]    seg_weight_q, seg_weight_d;
  logic [DATA_W-1:0]    value_q, value_d;
  logic                 bound_req_q, bound_req_d;
  logic                 sel_reset_q, sel_reset_d;
  logic                 sel_enable_q, sel_enable_d;
  logic                 samp_valid_q, samp_valid_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, datapath updates and registered control decode from the next state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    sweep_d      = sweep_q;
    run_sweeps_d = run_sweeps_q;
    target_d     = target_q;
    stop_d       = stop_q;
    lt_d         = lt_q;
    mt_d         = mt_q;
    flag_d       = flag_q;
    seg_type_d   = seg_type_q;
    seg_from_d   = seg_from_q;
    seg_to_d     = seg_to_q;
    seg_weight_d = seg_weight_q;
    value_d      = value_q;

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d      = S_REQ_BOUND;
          idx_d        = '0;
          run_sweeps_d = '0;
          target_d     = in_num_sweeps;
        end
      end
      S_REQ_BOUND: begin
        if (in_bound_valid) begin
          lt_d    = in_c_less_than;
          mt_d    = in_c_more_than;
          flag_d  = in_flag;
          state_d = (in_flag == 2'd0) ? S_NEXT : S_SEL_RST;
        end
      end
      S_SEL_RST: begin
        cnt_d   = '0;
        state_d = S_SEL_RUN;
      end
      S_SEL_RUN: begin
        if (cnt_q == CNT_LAST) begin
          seg_type_d   = in_seg_type;
          seg_from_d   = in_seg_from;
          seg_to_d     = in_seg_to;
          seg_weight_d = in_seg_weight;
          lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          state_d      = S_HANDOFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HANDOFF: begin
        if (in_samp_ready) state_d = S_WAIT_SAMP;
      end
      S_WAIT_SAMP: begin
        if (in_samp_done) begin
          value_d = in_samp_value;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (stop_q) begin
          state_d = S_DONE;
        end else if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          sweep_d      = sweep_q + 8'd1;
          run_sweeps_d = run_sweeps_q + 8'd1;
          if ((target_q != 8'd0) && (run_sweeps_d == target_q)) state_d = S_DONE;
          else                                                  state_d = S_REQ_BOUND;
        end else begin
          idx_d   = idx_q + VAR_IDX_W'(1);
          state_d = S_REQ_BOUND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stop request is remembered until the run actually ends.
    if (state_q == S_DONE)                      stop_d = 1'b0;
    else if ((state_q != S_IDLE) && in_stop)    stop_d = 1'b1;

    bound_req_d  = (state_d == S_REQ_BOUND);
    sel_reset_d  = (state_d == S_SEL_RST);
    sel_enable_d = (state_d == S_SEL_RUN);
    samp_valid_d = (state_d == S_HANDOFF);
    wr_en_d      = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers; reset holds the selector in reset.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      lfsr_q       <= SEED_INIT;
      sweep_q      <= '0;
      run_sweeps_q <= '0;
      target_q     <= '0;
      stop_q       <= 1'b0;
      lt_q         <= '0;
      mt_q         <= '0;
      flag_q       <= '0;
      seg_type_q   <= '0;
      seg_from_q   <= '0;
      seg_to_q     <= '0;
      seg_weight_q <= '0;
      value_q      <= '0;
      bound_req_q  <= 1'b0;
      sel_reset_q  <= 1'b1;
      sel_enable_q <= 1'b0;
      samp_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      sweep_q      <= sweep_d;
      run_sweeps_q <= run_sweeps_d;
      target_q     <= target_d;
      stop_q       <= stop_d;
      lt_q         <= lt_d;
      mt_q         <= mt_d;
      flag_q       <= flag_d;
      seg_type_q   <= seg_type_d;
      seg_from_q   <= seg_from_d;
      seg_to_q     <= seg_to_d;
      seg_weight_q <= seg_weight_d;
      value_q      <= value_d;
      bound_req_q  <= bound_req_d;
      sel_reset_q  <= sel_reset_d;
      sel_enable_q <= sel_enable_d;
      samp_valid_q <= samp_valid_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_bound_req       = bound_req_q;
  assign out_bound_var_idx   = idx_q;
  assign out_sel_reset       = sel_reset_q;
  assign out_sel_enable      = sel_enable_q;
  assign out_sel_seed        = lfsr_q;
  assign out_sel_c_less_than = lt_q;
  assign out_sel_c_more_than = mt_q;
  assign out_sel_flag        = flag_q;
  assign out_samp_valid      = samp_valid_q;
  assign out_samp_type       = seg_type_q;
  assign out_samp_from       = seg_from_q;
  assign out_samp_to         = seg_to_q;
  assign out_samp_weight     = seg_weight_q;
  assign out_wr_en           = wr_en_q;
  assign out_wr_var_idx      = idx_q;
  assign out_wr_value        = value_q;
  assign out_busy            = busy_q;
  assign out_done            = done_q;
  assign out_sweep_count     = sweep_q;

endmodule

// File: doc/gibbs_segment_scheduler.md
Name: gibbs_segment_scheduler

Overview:
- Sequences the segment selector across all solver variables in Gibbs-sweep order.
- Per variable: fetches bounds, resets and enables the selector, and captures the chosen segment after a fixed latency.
- Hands the segment to the value sampler, then writes the sampled value back to the variable store.
- Owns the selector seed (8-bit LFSR) and the sweep/stop bookkeeping.

Parameters:
- NUM_VARS, 4, number of variables per sweep (2..2^VAR_IDX_W).
- VAR_IDX_W, 2, variable index width.
- DATA_W, 8, signed bound/segment/value width.
- SEL_LATENCY, 2, cycles from selector enable rising to valid segment outputs (>=1).
- SEED_INIT, 8'd1, LFSR value after reset (must be nonzero).

Ports:
- in_clock in 1: clock.
- in_reset in 1: synchronous active-high reset.
- in_start in 1: pulse; begins a run when idle.
- in_stop in 1: request to end the run after the current variable.
- in_num_sweeps in 8: sweeps per run; 0 = continuous.
- out_bound_req out 1: bound fetch request.
- out_bound_var_idx out VAR_IDX_W: index being fetched.
- in_bound_valid in 1: bounds present this cycle.
- in_c_less_than, in_c_more_than in DATA_W: signed bounds.
- in_flag in 2: 0 skip, 1 both bounds, 2 greater-than only, 3 less-than only.
- out_sel_reset, out_sel_enable out 1: selector control.
- out_sel_seed out 8: selector seed.
- out_sel_c_less_than, out_sel_c_more_than out DATA_W; out_sel_flag out 2: latched bounds.
- in_seg_type in 2; in_seg_from, in_seg_to, in_seg_weight in DATA_W: selector results.
- out_samp_valid out 1; in_samp_ready in 1: segment handoff handshake.
- out_samp_type out 2; out_samp_from, out_samp_to, out_samp_weight out DATA_W: captured segment.
- in_samp_done in 1; in_samp_value in DATA_W: sampler result.
- out_wr_en out 1; out_wr_var_idx out VAR_IDX_W; out_wr_value out DATA_W: write-back.
- out_busy, out_done out 1: status (done is a one-cycle pulse).
- out_sweep_count out 8: completed sweeps, wraps 255->0.

Behaviour:
- Reset applies all-registered state on the clock edge with in_reset=1:
  - state IDLE;
  - every output 0, except out_sel_reset=1 while in_reset is high, and out_sel_seed=SEED_INIT;
  - var index 0, sweep count 0, stop latch cleared.
- Reset has priority over all inputs, including mid-run.
- IDLE: in_start=1 -> REQ_BOUND with idx=0 and out_busy=1. Target sweeps latched from in_num_sweeps. in_start is ignored when not in IDLE.
- REQ_BOUND:
  - out_bound_req=1 and out_bound_var_idx=idx, held until in_bound_valid=1 (valid in the same cycle as req is accepted).
  - On accept, bounds and flag are latched onto out_sel_*.
  - flag=0 -> NEXT (no selector call, no write). Otherwise -> SEL_RST.
- SEL_RST: out_sel_reset=1 for exactly 1 cycle -> SEL_RUN.
- SEL_RUN:
  - out_sel_enable=1 for SEL_LATENCY cycles, counted by an internal counter.
  - On the last cycle, in_seg_* are captured into out_samp_*.
  - LFSR advances once: next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
  - -> HANDOFF, with out_sel_enable=0.
- HANDOFF: out_samp_valid=1 with stable out_samp_* until in_samp_ready=1 -> WAIT_SAMP.
- WAIT_SAMP: in_samp_done=1 -> latch in_samp_value -> WRITE. A done arriving during HANDOFF is ignored.
- WRITE: out_wr_en=1 for 1 cycle, out_wr_var_idx=idx, out_wr_value=latched value -> NEXT.
- NEXT:
  - If the stop latch is set -> DONE.
  - Else if idx=NUM_VARS-1: idx=0 and sweep_count+1. Then if target!=0 and the sweep count reaches target -> DONE, else -> REQ_BOUND.
  - Else idx+1 -> REQ_BOUND.
- Stop latch: set by in_stop=1 in any non-IDLE state; cleared in DONE and on reset. in_stop in IDLE has no effect.
- DONE: out_done=1 for 1 cycle, out_busy=0 -> IDLE. out_sweep_count and the LFSR are retained across runs; only reset clears them.
- Continuous mode (target=0) runs until stop; sweep count wraps.
- No arithmetic on bounds: they are passed through unmodified, and sign is preserved.

Test Plan:
- Bounds 10/2, flag=1, NUM_VARS=4, num_sweeps=1, sampler always ready, done 3 cycles later with value 7:
  - 4 selector calls, each with a 1-cycle out_sel_reset then 2 enable cycles;
  - 4 writes of 7 to idx 0..3;
  - seeds 0x01, 0x02, 0x04, 0x08;
  - out_done pulse; sweep_count=1.
- Var 2 flag=0, others flag=1 (bounds -2/-10): no enable and no write for idx 2; writes to 0, 1, 3 only; LFSR advances 3 times.
- Hold in_samp_ready=0 for 5 cycles with in_samp_done pulsed during HANDOFF: out_samp_valid and data stable for all 5 cycles; the early done is ignored; the write happens only after a done in WAIT_SAMP.
- num_sweeps=0, assert in_stop during var 1 SEL_RUN of sweep 3: the var 1 write completes, then out_done; no request for var 2; sweep_count=2.
- Assert in_reset during WAIT_SAMP: next cycle all outputs 0, seed=0x01, state IDLE, no write. A new in_start then restarts at idx 0.
- in_bound_valid delayed 4 cycles, plus an in_start pulse mid-run: out_bound_req is held for 4 cycles with a stable index; the mid-run start has no effect.
